// File: rtl/riscv_instr_queue_if.sv
// Handshake bundle between the MIPS->RISC-V translator, the instruction queue and the IDU.
// The queue takes the slave view; the surrounding pipeline (or a bench) takes the master view.
interface riscv_instr_queue_if #(
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic [31:0]   in_instr;
    logic          in_valid;
    logic          in_error;
    logic          in_accepted;
    logic [31:0]   out_instr;
    logic          out_valid;
    logic          out_error;
    logic          out_accepted;
    logic [CW-1:0] count;
    logic          afull;

    modport slave (
        input  flush,
        input  in_instr,
        input  in_valid,
        input  in_error,
        output in_accepted,
        output out_instr,
        output out_valid,
        output out_error,
        input  out_accepted,
        output count,
        output afull
    );

    modport master (
        output flush,
        output in_instr,
        output in_valid,
        output in_error,
        input  in_accepted,
        input  out_instr,
        input  out_valid,
        input  out_error,
        output out_accepted,
        input  count,
        input  afull
    );
endinterface

// File: rtl/riscv_instr_queue.sv
// Elastic FIFO between the translator output and the IDU input, carrying each word with
// its error flag; flushable on redirect. Registered-only outputs, no empty bypass.
module riscv_instr_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AFULL_TH = 3
) (
    input  logic                 clk,
    input  logic                 pipe_rst,
    riscv_instr_queue_if.slave   iq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] AFULL_CNT = PW'(AFULL_TH);
    localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);

    typedef struct packed {
        logic        error;
        logic [31:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [AW-1:0] wr_idx, rd_idx;
    logic          empty, full;
    logic          push, pop;
    logic [PW-1:0] occupancy;

    always_comb begin
        wr_idx    = wr_ptr_q[AW-1:0];
        rd_idx    = rd_ptr_q[AW-1:0];
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        occupancy = wr_ptr_q - rd_ptr_q;
        // Decisions depend only on registered state and the request inputs,
        // so out_accepted never reaches in_accepted combinationally.
        push      = iq.in_valid && !full && !iq.flush;
        pop       = !empty && iq.out_accepted && !iq.flush;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (iq.flush) begin
            wr_ptr_d = rd_ptr_q;
        end else begin
            if (push) begin
                mem_d[wr_idx] = '{error: iq.in_error, instr: iq.in_instr};
                wr_ptr_d      = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pipe_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: it is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        iq.in_accepted = push;
        iq.out_valid   = !empty;
        iq.out_instr   = mem_q[rd_idx].instr;
        iq.out_error   = mem_q[rd_idx].error;
        iq.count       = occupancy;
        iq.afull       = (occupancy >= AFULL_CNT);
    end

    a_count_le_depth: assert property (@(posedge clk) disable iff (pipe_rst)
        occupancy <= DEPTH_CNT);
    a_no_push_full:   assert property (@(posedge clk) disable iff (pipe_rst)
        push |-> !full);
    a_no_pop_empty:   assert property (@(posedge clk) disable iff (pipe_rst)
        pop |-> !empty);

endmodule
